sprite_blitter: RTL

- Upstream writer for the 700x480 4-bit palette-index frame buffer RAM.
- On a START pulse, copies a rectangular sprite from a synchronous sprite ROM into the frame buffer at (SPR_X, SPR_Y).
- Skips transparent pixels and clips pixels that fall off the frame.
- Drives the frame buffer's write port (data_in, WRITE_ADDR, WE) directly; the VGA side keeps the read port.

---
 rtl/frame_pkg.sv | 37 +++
 rtl/blit_addr_gen.sv | 95 +++++++++
 rtl/sprite_blitter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// ============================================================================
// Module      : frame_pkg
// Description : Shared frame-buffer geometry, pixel/address types and blitter
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_pkg;

    localparam int FRAME_W  = 700;
    localparam int FRAME_H  = 480;
    localparam int FRAME_AW = 19;

    typedef logic [3:0]          pix_idx_t;
    typedef logic [FRAME_AW-1:0] frame_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

    // Shift-and-add row*fw, evaluated once per blit to seed the incremental row base.
    function automatic frame_addr_t row_base_of(input logic [8:0] row, input int fw);
        frame_addr_t acc;
        acc = '0;
        for (int i = 0; i < FRAME_AW; i++) begin
            if (fw[i]) acc = acc + (frame_addr_t'(row) << i);
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blit_addr_gen.sv
// ============================================================================
// Module      : blit_addr_gen
// Description : Row/column walker for the sprite blitter; produces the ROM
//               read address, destination address, clip and last-pixel flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blit_addr_gen
    import frame_pkg::*;
#(
    parameter int ROM_AW  = 16,
    parameter int FRAME_W = 700,
    parameter int FRAME_H = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic [9:0]        i_w,
    input  logic [8:0]        i_h,
    input  logic [ROM_AW-1:0] i_base,
    input  logic              i_hflip,
    output logic [ROM_AW-1:0] o_rom_addr,
    output frame_addr_t       o_dst_addr,
    output logic              o_clip_ok,
    output logic              o_last
);

    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic [9:0]        r_w;
    logic [8:0]        r_h;
    logic              r_hflip;
    logic [9:0]        r_col;
    logic [8:0]        r_row;
    logic [ROM_AW-1:0] r_rom_row_base;
    frame_addr_t       r_dst_row_base;

    logic              w_col_last;
    logic              w_row_last;
    logic [10:0]       w_dst_col;
    logic [9:0]        w_dst_row;
    logic [9:0]        w_src_col;

    assign w_col_last = (r_col == r_w - 10'd1);
    assign w_row_last = (r_row == r_h - 9'd1);
    // Widened sums so an off-frame origin plus offset cannot wrap back on-screen.
    assign w_dst_col  = {1'b0, r_x} + {1'b0, r_col};
    assign w_dst_row  = {1'b0, r_y} + {1'b0, r_row};
    assign w_src_col  = r_hflip ? (r_w - 10'd1 - r_col) : r_col;

    assign o_rom_addr = r_rom_row_base + ROM_AW'(w_src_col);
    assign o_dst_addr = r_dst_row_base + FRAME_AW'(w_dst_col);
    assign o_clip_ok  = (w_dst_col < 11'(FRAME_W)) && (w_dst_row < 10'(FRAME_H));
    assign o_last     = w_col_last && w_row_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x            <= '0;
            r_y            <= '0;
            r_w            <= '0;
            r_h            <= '0;
            r_hflip        <= 1'b0;
            r_col          <= '0;
            r_row          <= '0;
            r_rom_row_base <= '0;
            r_dst_row_base <= '0;
        end else if (i_load) begin
            r_x            <= i_x;
            r_y            <= i_y;
            r_w            <= i_w;
            r_h            <= i_h;
            r_hflip        <= i_hflip;
            r_col          <= '0;
            r_row          <= '0;
            r_rom_row_base <= i_base;
            r_dst_row_base <= row_base_of(i_y, FRAME_W);
        end else if (i_step) begin
            if (w_col_last) begin
                r_col          <= '0;
                r_row          <= r_row + 9'd1;
                r_rom_row_base <= r_rom_row_base + ROM_AW'(r_w);
                r_dst_row_base <= r_dst_row_base + FRAME_AW'(FRAME_W);
            end else begin
                r_col          <= r_col + 10'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
// Module      : sprite_blitter
// Description : Copies a sprite from a synchronous ROM into the frame buffer
//               with transparency skip and edge clipping.
//               Optional mirrored reads: define SPRITE_BLITTER_HFLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_blitter
    import frame_pkg::*;
#(
    parameter int       FRAME_W         = frame_pkg::FRAME_W,
    parameter int       FRAME_H         = frame_pkg::FRAME_H,
    parameter int       ROM_AW          = 16,
    parameter pix_idx_t TRANSPARENT_IDX = 4'h0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [9:0]        SPR_X,
    input  logic [8:0]        SPR_Y,
    input  logic [9:0]        SPR_W,
    input  logic [8:0]        SPR_H,
    input  logic [ROM_AW-1:0] SPR_BASE,
`ifdef SPRITE_BLITTER_HFLIP_EN
    input  logic              HFLIP,
`endif
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  pix_idx_t          ROM_DATA,
    output frame_addr_t       WRITE_ADDR,
    output pix_idx_t          data_in,
    output logic              WE,
    output logic              BUSY,
    output logic              DONE
);

    blit_state_t r_state;
    blit_state_t w_state_nxt;

    logic        w_hflip;
    logic        w_load;
    logic        w_step;
    frame_addr_t w_dst_addr;
    logic        w_clip_ok;
    logic        w_last;

    logic        r_wr_valid;
    logic        r_clip_ok;
    frame_addr_t r_wr_addr;

`ifdef SPRITE_BLITTER_HFLIP_EN
    assign w_hflip = HFLIP;
`else
    assign w_hflip = 1'b0;
`endif

    assign w_load = (r_state == IDLE) && START;
    assign w_step = (r_state == RUN);

    blit_addr_gen #(
        .ROM_AW  (ROM_AW),
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H)
    ) u_addr_gen (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_x        (SPR_X),
        .i_y        (SPR_Y),
        .i_w        (SPR_W),
        .i_h        (SPR_H),
        .i_base     (SPR_BASE),
        .i_hflip    (w_hflip),
        .o_rom_addr (ROM_ADDR),
        .o_dst_addr (w_dst_addr),
        .o_clip_ok  (w_clip_ok),
        .o_last     (w_last)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt = (SPR_W == 10'd0 || SPR_H == 9'd0) ? frame_pkg::DONE : RUN;
                end
            end
            RUN:            if (w_last) w_state_nxt = DRAIN;
            DRAIN:          w_state_nxt = frame_pkg::DONE;
            frame_pkg::DONE: w_state_nxt = IDLE;
            default:        w_state_nxt = IDLE;
        endcase
    end

    // Destination address and clip flag ride one stage so they meet ROM_DATA.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_valid <= 1'b0;
            r_clip_ok  <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_wr_valid <= w_step;
            r_clip_ok  <= w_clip_ok;
            r_wr_addr  <= w_dst_addr;
        end
    end

    assign WRITE_ADDR = r_wr_addr;
    assign data_in    = r_wr_valid ? ROM_DATA : '0;
    assign WE         = r_wr_valid && r_clip_ok && (ROM_DATA != TRANSPARENT_IDX);
    assign BUSY       = (r_state == RUN) || (r_state == DRAIN);
    assign DONE       = (r_state == frame_pkg::DONE);

endmodule

`default_nettype wire
